// File: rtl/uart_pkg.sv
// Purpose : shared constants for the UART transmitter (baud rates, parity modes, FSM states).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Supported line rates in bits per second
  localparam int BAUD_9600   = 9600;
  localparam int BAUD_19200  = 19200;
  localparam int BAUD_38400  = 38400;
  localparam int BAUD_57600  = 57600;
  localparam int BAUD_115200 = 115200;

  // Parity_mode encoding; code 3 behaves like "none"
  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } parity_mode_e;

  // Transmit FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Purpose : bit-period divider; emits a one-cycle bit_tick at the last clock of each bit period.
// Latency : first tick period-1 cycles after clear drops (counter runs 0..period-1).
// Backpressure: none; clear holds the counter at 0.
// Ports   : Clk, Rst_n (async active-low), clear (hold/restart), Baud_sel[2:0]
//           (0=9600,1=19200,2=38400,3=57600,4=115200,5..7=9600), bit_tick (out).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       clear,
  input  logic [2:0] Baud_sel,
  output logic       bit_tick
);

  // Sized for the slowest rate so no period can wrap the counter
  localparam int PER_MAX = CLK_FREQ / BAUD_9600;
  localparam int CNT_W   = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;

  localparam int PER_9600   = CLK_FREQ / BAUD_9600;
  localparam int PER_19200  = CLK_FREQ / BAUD_19200;
  localparam int PER_38400  = CLK_FREQ / BAUD_38400;
  localparam int PER_57600  = CLK_FREQ / BAUD_57600;
  localparam int PER_115200 = CLK_FREQ / BAUD_115200;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic             w_tick;

  always_comb begin
    w_last = CNT_W'(PER_9600 - 1);
    case (Baud_sel)
      3'd1:    w_last = CNT_W'(PER_19200 - 1);
      3'd2:    w_last = CNT_W'(PER_38400 - 1);
      3'd3:    w_last = CNT_W'(PER_57600 - 1);
      3'd4:    w_last = CNT_W'(PER_115200 - 1);
      default: w_last = CNT_W'(PER_9600 - 1);
    endcase
  end

  assign w_tick   = !clear && (r_cnt == w_last);
  assign bit_tick = w_tick;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (clear || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Purpose : UART frame transmitter (start, DATA_W bits LSB first, optional parity, 1 or 2 stop bits).
// Latency : start bit on Uart_tx the cycle after an accepted En; Tx_done the cycle after the last stop period.
// Backpressure: none; En is ignored (not queued) while Uart_state=1, accepted again in the Tx_done cycle.
// Ports   : Clk, Rst_n (async active-low), En, Baud_sel[2:0], Parity_mode[1:0] (0/3 none,1 even,2 odd),
//           Stop2, Data_byte[DATA_W-1:0]; out Uart_tx (registered, idle high), Uart_state (busy), Tx_done (pulse).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int DATA_W   = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic [2:0]        Baud_sel,
  input  logic [1:0]        Parity_mode,
  input  logic              Stop2,
  input  logic [DATA_W-1:0] Data_byte,
  output logic              Uart_tx,
  output logic              Uart_state,
  output logic              Tx_done
);

  localparam int               BIT_W    = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [BIT_W-1:0]  w_bit_cnt_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [2:0]        r_baud_sel;
  logic              r_par_en;
  logic              r_par_bit;
  logic              r_stop2;
  logic              r_tx;
  logic              r_done;
  logic              w_accept;
  logic              w_tick;
  logic              w_clear;
  logic              w_tx_nxt;
  logic              w_done_nxt;

  assign w_accept = (r_state == ST_IDLE) && En;

  // Divider is held cleared in IDLE so the start bit gets a full period from the accept edge
  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud_gen (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .clear    (w_clear),
    .Baud_sel (r_baud_sel),
    .bit_tick (w_tick)
  );

  // State register plus captured frame configuration
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_baud_sel <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_done    <= w_done_nxt;
      if (w_accept) begin
        r_baud_sel <= Baud_sel;
        r_par_en   <= (Parity_mode == PAR_EVEN) || (Parity_mode == PAR_ODD);
        // Parity is fixed at capture time: XOR of data, inverted for odd
        r_par_bit  <= (^Data_byte) ^ (Parity_mode == PAR_ODD);
        r_stop2    <= Stop2;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    case (r_state)
      ST_IDLE: begin
        if (En) begin
          w_state_nxt   = ST_START;
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = Data_byte;
        end
      end
      ST_START: begin
        if (w_tick) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // bit counter doubles as the stop-period counter
        if (w_tick) begin
          if (r_stop2 && (r_bit_cnt == '0)) begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end else begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: line level is decided from the next state and registered, so it is glitch-free
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
      ST_PARITY: w_tx_nxt = r_par_bit;
      default:   w_tx_nxt = 1'b1;
    endcase
    w_done_nxt = (r_state == ST_STOP) && (w_state_nxt == ST_IDLE);
    w_clear    = (r_state == ST_IDLE);
  end

  assign Uart_tx    = r_tx;
  assign Uart_state = (r_state != ST_IDLE);
  assign Tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

  localparam int CLK_FREQ = 50000000;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       En;
  logic [2:0] Baud_sel;
  logic [1:0] Parity_mode;
  logic       Stop2;
  logic [7:0] Data_byte;
  logic       Uart_tx;
  logic       Uart_state;
  logic       Tx_done;

  int n_pass    = 0;
  int n_total   = 0;
  int g_poke_k  = -1;
  bit g_hold_en = 1'b0;

  uart_tx_frame #(
    .CLK_FREQ (CLK_FREQ),
    .DATA_W   (8)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .En          (En),
    .Baud_sel    (Baud_sel),
    .Parity_mode (Parity_mode),
    .Stop2       (Stop2),
    .Data_byte   (Data_byte),
    .Uart_tx     (Uart_tx),
    .Uart_state  (Uart_state),
    .Tx_done     (Tx_done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bit period from the baud table, plain integer division
  function automatic int period_of(input logic [2:0] sel);
    case (sel)
      3'd1:    return CLK_FREQ / 19200;
      3'd2:    return CLK_FREQ / 38400;
      3'd3:    return CLK_FREQ / 57600;
      3'd4:    return CLK_FREQ / 115200;
      default: return CLK_FREQ / 9600;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_watch(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (Uart_tx !== 1'b1 || Uart_state !== 1'b0 || Tx_done !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Called at a negedge with En=1 driven; returns at the negedge of the Tx_done cycle.
  task automatic expect_frame(input logic [7:0] data, input logic [2:0] bsel,
                              input logic [1:0] pm, input logic st2, input string tag);
    logic lv[$];
    int   per;
    int   len;
    int   bad;
    int   b;
    per = period_of(bsel);
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(data[i]);
    if (pm == 2'd1) lv.push_back(^data);
    else if (pm == 2'd2) lv.push_back(~^data);
    lv.push_back(1'b1);
    if (st2) lv.push_back(1'b1);
    len = lv.size() * per;
    bad = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge Clk);
      if (k == 0 && !g_hold_en) En = 1'b0;
      if (g_poke_k >= 0 && k == g_poke_k) begin
        En          = 1'b1;
        Data_byte   = ~data;
        Parity_mode = 2'd2;
        Stop2       = 1'b1;
        Baud_sel    = 3'd0;
      end
      if (g_poke_k >= 0 && k == g_poke_k + 1) En = 1'b0;
      if (k == 0) chk($sformatf("%s busy at start", tag), Uart_state, 1'b1);
      b = k / per;
      if (Uart_tx !== lv[b] || Uart_state !== 1'b1 || Tx_done !== 1'b0) bad++;
      if (k % per == 0)
        chk($sformatf("%s bit%0d first cycle", tag, b), Uart_tx, lv[b]);
      if (k % per == per - 1)
        chk($sformatf("%s bit%0d last cycle", tag, b), Uart_tx, lv[b]);
    end
    chk($sformatf("%s body mismatching cycles", tag), bad, 0);
    @(negedge Clk);
    chk($sformatf("%s Tx_done at %0d", tag, len), Tx_done, 1'b1);
    chk($sformatf("%s Uart_state at done", tag), Uart_state, 1'b0);
    chk($sformatf("%s line idle at done", tag), Uart_tx, 1'b1);
  endtask

  initial begin
    logic [7:0] rnd_d;
    logic [1:0] rnd_pm;
    logic       rnd_st;

    Rst_n = 1'b0; En = 1'b0; Baud_sel = 3'd4; Parity_mode = 2'd0; Stop2 = 1'b0; Data_byte = 8'h00;
    repeat (3) @(negedge Clk);
    chk("reset Uart_tx", Uart_tx, 1'b1);
    chk("reset Uart_state", Uart_state, 1'b0);
    chk("reset Tx_done", Tx_done, 1'b0);
    Rst_n = 1'b1;
    idle_watch(4, "idle after reset");

    // Even parity on 0xA5, with an En pulse plus changed inputs mid-frame
    Baud_sel = 3'd4; Parity_mode = 2'd1; Stop2 = 1'b0; Data_byte = 8'hA5; En = 1'b1;
    g_poke_k = 434 * 4 + 7;
    expect_frame(8'hA5, 3'd4, 2'd1, 1'b0, "even A5");
    g_poke_k = -1;
    idle_watch(3 * 434, "no queued frame after mid-frame En");

    // Odd parity on 0xA5
    Baud_sel = 3'd4; Parity_mode = 2'd2; Stop2 = 1'b0; Data_byte = 8'hA5; En = 1'b1;
    expect_frame(8'hA5, 3'd4, 2'd2, 1'b0, "odd A5");

    // En held high: 0x55 at 115200, then the value presented in the Tx_done cycle
    Baud_sel = 3'd4; Parity_mode = 2'd0; Stop2 = 1'b0; Data_byte = 8'h55; En = 1'b1;
    g_hold_en = 1'b1;
    expect_frame(8'h55, 3'd4, 2'd0, 1'b0, "b2b first 55");
    rnd_d  = 8'($urandom);
    rnd_pm = 2'($urandom_range(0, 3));
    rnd_st = 1'($urandom_range(0, 1));
    Data_byte = rnd_d; Parity_mode = rnd_pm; Stop2 = rnd_st;
    expect_frame(rnd_d, 3'd4, rnd_pm, rnd_st, "b2b second");
    En = 1'b0;
    g_hold_en = 1'b0;
    idle_watch(20, "idle after b2b");

    // Reset pulse during DATA, then a fresh frame on the first edge after release
    rnd_d = 8'($urandom);
    Baud_sel = 3'd4; Parity_mode = 2'd0; Stop2 = 1'b0; Data_byte = rnd_d; En = 1'b1;
    @(negedge Clk);
    En = 1'b0;
    repeat (434 * 3) @(negedge Clk);
    chk("busy before mid-frame reset", Uart_state, 1'b1);
    #2 Rst_n = 1'b0;
    #1;
    chk("async reset Uart_tx", Uart_tx, 1'b1);
    chk("async reset Uart_state", Uart_state, 1'b0);
    chk("async reset Tx_done", Tx_done, 1'b0);
    @(negedge Clk);
    rnd_d  = 8'($urandom);
    rnd_pm = 2'($urandom_range(0, 3));
    rnd_st = 1'($urandom_range(0, 1));
    Data_byte = rnd_d; Parity_mode = rnd_pm; Stop2 = rnd_st; Baud_sel = 3'd4;
    Rst_n = 1'b1; En = 1'b1;
    expect_frame(rnd_d, 3'd4, rnd_pm, rnd_st, "after reset");

    // Baud_sel=7 falls back to 9600, two stop bits
    rnd_d = 8'($urandom);
    Baud_sel = 3'd7; Parity_mode = 2'd0; Stop2 = 1'b1; Data_byte = rnd_d; En = 1'b1;
    expect_frame(rnd_d, 3'd7, 2'd0, 1'b1, "sel7 stop2");
    idle_watch(4, "idle at end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
